u_lsu: RTL

U_LSU -- requirements
Module: u_lsu

---
 rtl/u_lsu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/u_lsu.sv
// RV32I load/store unit: one outstanding bus access, lane steering for stores,
// load-data extraction/extension, and a bounded wait for the read response.
module u_lsu #(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lsu_vld,
  output logic        lsu_rdy,
  input  logic        lsu_ld,
  input  logic        lsu_st,
  input  logic [2:0]  lsu_f3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [4:0]  lsu_rd_a,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_e,
  output logic [4:0]  wb_a,
  output logic [31:0] wb_d,
  output logic        lsu_err
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(RSP_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q;
  logic        err_q, err_d;
  logic        wb_e_q, wb_e_d;
  logic [4:0]  wb_a_q, wb_a_d;
  logic [31:0] wb_d_q, wb_d_d;

  logic        accept, illegal, misaligned;
  logic [3:0]  be;
  logic [31:0] st_data, rsh, ld_data;

  assign accept = lsu_vld & (state_q == StIdle);

  always_comb begin
    illegal = (lsu_ld == lsu_st) |
              (lsu_ld & (lsu_f3 inside {3'd3, 3'd6, 3'd7})) |
              (lsu_st & (lsu_f3 >= 3'd3));
    misaligned = ((lsu_f3[1:0] == 2'd1) & lsu_addr[0]) |
                 ((lsu_f3[1:0] == 2'd2) & (lsu_addr[1:0] != 2'd0));
  end

  // Lane steering from the captured request
  always_comb begin
    case (f3_q[1:0])
      2'd0: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be      = 4'b0011 << {addr_q[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    rsh = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'd0:    ld_data = {{24{rsh[7]}}, rsh[7:0]};
      3'd4:    ld_data = {24'd0, rsh[7:0]};
      3'd1:    ld_data = addr_q[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                   : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd5:    ld_data = addr_q[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    lsu_rdy   = (state_q == StIdle);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    if (state_q == StReq) begin
      mem_req   = 1'b1;
      mem_we    = st_q;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_be    = be;
      mem_wdata = st_q ? st_data : 32'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wb_e_d  = 1'b0;
    wb_a_d  = 5'd0;
    wb_d_d  = 32'd0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (illegal | misaligned) err_d = 1'b1;
          else state_d = StReq;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          state_d = st_q ? StIdle : StRsp;
          cnt_d   = 8'd0;
        end
      end
      StRsp: begin
        if (mem_rvalid) begin
          state_d = StIdle;
          if (rd_q != 5'd0) begin
            wb_e_d = 1'b1;
            wb_a_d = rd_q;
            wb_d_d = ld_data;
          end
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
          if (cnt_d == TimeoutCnt) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      wb_e_q  <= 1'b0;
      wb_a_q  <= 5'd0;
      wb_d_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wb_e_q  <= wb_e_d;
      wb_a_q  <= wb_a_d;
      wb_d_q  <= wb_d_d;
      if (accept) begin
        st_q    <= lsu_st;
        f3_q    <= lsu_f3;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        rd_q    <= lsu_rd_a;
      end
    end
  end

  assign lsu_err = err_q;
  assign wb_e    = wb_e_q;
  assign wb_a    = wb_a_q;
  assign wb_d    = wb_d_q;

endmodule
